// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_stage
// Brief    : Execute + writeback stage of the 8-bit core. Single-cycle ALU
//            ops with registered register-file write port and Z/C/N/V flags;
//            MULL/MULH run on an 8-iteration shift-add multiplier that stalls
//            decode through the valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_wb_stage #(
    parameter int MUL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [3:0] in_rd,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_wb_en,
    output logic       reg_write_en,
    output logic [3:0] reg_write_addr,
    output logic [7:0] reg_write_data,
    output logic [3:0] flags,
    output logic       busy
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_ADC  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_SBC  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_NOT  = 4'h7;
    localparam logic [3:0] c_OP_SHL  = 4'h8;
    localparam logic [3:0] c_OP_SHR  = 4'h9;
    localparam logic [3:0] c_OP_ASR  = 4'hA;
    localparam logic [3:0] c_OP_MOV  = 4'hB;
    localparam logic [3:0] c_OP_CMP  = 4'hC;
    localparam logic [3:0] c_OP_MULL = 4'hD;
    localparam logic [3:0] c_OP_MULH = 4'hE;
    localparam logic [3:0] c_OP_NOP  = 4'hF;

    localparam logic [2:0] c_CNT_LAST = 3'(MUL_CYCLES - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [3:0]  r_rd;
    logic        r_wb_en;
    logic        r_is_high;
    logic [15:0] r_prod;
    logic [2:0]  r_cnt;

    logic        w_accept;
    logic        w_is_mul;
    logic [8:0]  w_sum;
    logic [7:0]  w_res;
    logic        w_c;
    logic        w_v;
    logic        w_alu_upd;
    logic        w_alu_we;
    logic [15:0] w_addend;
    logic [15:0] w_prod_next;
    logic [7:0]  w_mul_res;

    assign in_ready = (r_state == c_ST_IDLE);
    assign busy     = (r_state == c_ST_MUL);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (in_op == c_OP_MULL) || (in_op == c_OP_MULH);

    // Multiplier iteration: add a<<i when b[i] is set; final byte chosen by MULL/MULH.
    assign w_addend    = r_b[r_cnt] ? ({8'h00, r_a} << r_cnt) : 16'h0000;
    assign w_prod_next = r_prod + w_addend;
    assign w_mul_res   = r_is_high ? w_prod_next[15:8] : w_prod_next[7:0];

    // Single-cycle ALU: result, carry/borrow and overflow; C defaults to held value.
    always_comb begin
        w_sum     = 9'h000;
        w_res     = 8'h00;
        w_c       = flags[2];
        w_v       = 1'b0;
        w_alu_upd = 1'b1;
        w_alu_we  = in_wb_en;
        case (in_op)
            c_OP_ADD, c_OP_ADC: begin
                w_sum = {1'b0, in_a} + {1'b0, in_b} + {8'h00, (in_op == c_OP_ADC) & flags[2]};
                w_res = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (in_a[7] == in_b[7]) && (w_res[7] != in_a[7]);
            end
            c_OP_SUB, c_OP_SBC, c_OP_CMP: begin
                // Bit 8 of the 9-bit difference is the borrow.
                w_sum    = {1'b0, in_a} - {1'b0, in_b} - {8'h00, (in_op == c_OP_SBC) & flags[2]};
                w_res    = w_sum[7:0];
                w_c      = w_sum[8];
                w_v      = (in_a[7] != in_b[7]) && (w_res[7] != in_a[7]);
                w_alu_we = in_wb_en && (in_op != c_OP_CMP);
            end
            c_OP_AND: w_res = in_a & in_b;
            c_OP_OR:  w_res = in_a | in_b;
            c_OP_XOR: w_res = in_a ^ in_b;
            c_OP_NOT: w_res = ~in_a;
            c_OP_SHL: begin
                w_res = {in_a[6:0], 1'b0};
                w_c   = in_a[7];
                w_v   = in_a[7] ^ in_a[6];
            end
            c_OP_SHR: begin
                w_res = {1'b0, in_a[7:1]};
                w_c   = in_a[0];
            end
            c_OP_ASR: begin
                w_res = {in_a[7], in_a[7:1]};
                w_c   = in_a[0];
            end
            c_OP_MOV: w_res = in_b;
            c_OP_MULL, c_OP_MULH, c_OP_NOP: begin
                // Multiplies finish in the MUL state; NOP touches nothing.
                w_alu_upd = 1'b0;
                w_alu_we  = 1'b0;
            end
            default: begin
                w_alu_upd = 1'b0;
                w_alu_we  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: enter MUL on an accepted multiply, leave after the last iteration.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept && w_is_mul) w_state_next = c_ST_MUL;
            c_ST_MUL:  if (r_cnt == c_CNT_LAST)  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath: multiplier operands/product and the registered writeback port and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a            <= 8'h00;
            r_b            <= 8'h00;
            r_rd           <= 4'h0;
            r_wb_en        <= 1'b0;
            r_is_high      <= 1'b0;
            r_prod         <= 16'h0000;
            r_cnt          <= 3'd0;
            reg_write_en   <= 1'b0;
            reg_write_addr <= 4'h0;
            reg_write_data <= 8'h00;
            flags          <= 4'h0;
        end else begin
            reg_write_en <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (w_accept && w_is_mul) begin
                    r_a       <= in_a;
                    r_b       <= in_b;
                    r_rd      <= in_rd;
                    r_wb_en   <= in_wb_en;
                    r_is_high <= (in_op == c_OP_MULH);
                    r_prod    <= 16'h0000;
                    r_cnt     <= 3'd0;
                end else if (w_accept) begin
                    if (w_alu_upd) begin
                        flags <= {(w_res == 8'h00), w_c, w_res[7], w_v};
                    end
                    if (w_alu_we) begin
                        reg_write_en   <= 1'b1;
                        reg_write_addr <= in_rd;
                        reg_write_data <= w_res;
                    end
                end
            end else begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + 3'd1;
                if (r_cnt == c_CNT_LAST) begin
                    flags <= {(w_mul_res == 8'h00), (w_prod_next[15:8] != 8'h00), w_mul_res[7], 1'b0};
                    if (r_wb_en) begin
                        reg_write_en   <= 1'b1;
                        reg_write_addr <= r_rd;
                        reg_write_data <= w_mul_res;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wb_stage
// Brief    : Self-checking bench for alu_wb_stage: directed scenarios plus a
//            randomized operation stream compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_rd;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_wb_en;
    logic       reg_write_en;
    logic [3:0] reg_write_addr;
    logic [7:0] reg_write_data;
    logic [3:0] flags;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] mf = 4'h0;

    alu_wb_stage #(.MUL_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .in_wb_en(in_wb_en),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: returns {write, result, flags} from plain integer arithmetic.
    function automatic logic [12:0] model_op(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic wb, input logic [3:0] f);
        int ua, ub, sa, sb, cin, s, ss, p, r;
        logic c, v, upd, we;
        logic [7:0] r8;
        ua = int'(a);  ub = int'(b);
        sa = int'($signed(a));  sb = int'($signed(b));
        cin = f[2] ? 1 : 0;
        c = f[2];  v = 1'b0;  upd = 1'b1;  we = wb;  r = 0;
        p = ua * ub;
        case (op)
            4'h0, 4'h1: begin
                s  = ua + ub + ((op == 4'h1) ? cin : 0);
                ss = sa + sb + ((op == 4'h1) ? cin : 0);
                r = s % 256;  c = (s > 255);  v = (ss > 127) || (ss < -128);
            end
            4'h2, 4'h3, 4'hC: begin
                s  = ua - ub - ((op == 4'h3) ? cin : 0);
                ss = sa - sb - ((op == 4'h3) ? cin : 0);
                r = (s + 256) % 256;  c = (s < 0);  v = (ss > 127) || (ss < -128);
                if (op == 4'hC) we = 1'b0;
            end
            4'h4: r = int'(a & b);
            4'h5: r = int'(a | b);
            4'h6: r = int'(a ^ b);
            4'h7: r = 255 - ua;
            4'h8: begin r = (ua * 2) % 256; c = (ua >= 128); v = (ua >= 128) != ((ua % 128) >= 64); end
            4'h9: begin r = ua / 2; c = (ua % 2) == 1; end
            4'hA: begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = (ua % 2) == 1; end
            4'hB: r = ub;
            4'hD: begin r = p % 256; c = (p > 255); end
            4'hE: begin r = p / 256; c = (p > 255); end
            default: begin upd = 1'b0; we = 1'b0; end
        endcase
        r8 = r[7:0];
        return {we, r8, upd ? {(r8 == 8'h00), c, r8[7], v} : f};
    endfunction

    task automatic present(input logic [3:0] op, input logic [3:0] rd,
                           input logic [7:0] a, input logic [7:0] b, input logic wb);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_a = a; in_b = b; in_wb_en = wb;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_op = 4'hF; in_rd = 4'h0; in_a = 8'h00; in_b = 8'h00; in_wb_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step(); step();
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready} !== {1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b addr=%h data=%h flags=%b busy=%b rdy=%b, want 0/0/00/0000/0/1",
                     reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready);
        end
        rst = 1'b0;
        mf = 4'h0;
        step();
    endtask

    task automatic test_add_overflow();
        present(4'h0, 4'd3, 8'h7F, 8'h01, 1'b1);
        step();
        idle();
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags} !== {1'b1, 4'd3, 8'h80, 4'b0011}) begin
            n_fail++;
            $display("FAIL add_overflow: got we=%b addr=%h data=%h flags=%b, want 1/3/80/0011",
                     reg_write_en, reg_write_addr, reg_write_data, flags);
        end
        mf = 4'b0011;
        step();
        n_tests++;
        if (reg_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL add_single_pulse: got we=%b, want 0", reg_write_en);
        end
    endtask

    task automatic test_back_to_back();
        present(4'h2, 4'd1, 8'h05, 8'h05, 1'b1);
        step();
        present(4'h3, 4'd2, 8'h00, 8'h00, 1'b1);
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags, in_ready} !== {1'b1, 4'd1, 8'h00, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_sub: got we=%b addr=%h data=%h flags=%b rdy=%b, want 1/1/00/1000/1",
                     reg_write_en, reg_write_addr, reg_write_data, flags, in_ready);
        end
        step();
        idle();
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags, in_ready} !== {1'b1, 4'd2, 8'h00, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_sbc: got we=%b addr=%h data=%h flags=%b rdy=%b, want 1/2/00/1000/1",
                     reg_write_en, reg_write_addr, reg_write_data, flags, in_ready);
        end
        mf = 4'b1000;
        step();
    endtask

    task automatic test_mul_ff();
        int stall_bad;
        stall_bad = 0;
        present(4'hD, 4'd7, 8'hFF, 8'hFF, 1'b1);
        step();
        idle();
        for (int k = 0; k < 8; k++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1 || reg_write_en !== 1'b0) stall_bad++;
            step();
        end
        n_tests++;
        if (stall_bad != 0) begin
            n_fail++;
            $display("FAIL mull_stall: got %0d bad stall cycles, want 0", stall_bad);
        end
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready} !== {1'b1, 4'd7, 8'h01, 4'b0100, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mull_ff: got we=%b addr=%h data=%h flags=%b busy=%b rdy=%b, want 1/7/01/0100/0/1",
                     reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready);
        end
        mf = 4'b0100;
        step();
    endtask

    task automatic test_mul_hold_off();
        int early;
        early = 0;
        present(4'hE, 4'd4, 8'h10, 8'h10, 1'b1);
        step();
        present(4'h0, 4'd5, 8'h22, 8'h11, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (in_ready !== 1'b0 || reg_write_en !== 1'b0) early++;
            step();
        end
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL mulh_holdoff: got %0d cycles with ready/write during multiply, want 0", early);
        end
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags} !== {1'b1, 4'd4, 8'h01, 4'b0100}) begin
            n_fail++;
            $display("FAIL mulh_write: got we=%b addr=%h data=%h flags=%b, want 1/4/01/0100",
                     reg_write_en, reg_write_addr, reg_write_data, flags);
        end
        step();
        idle();
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags} !== {1'b1, 4'd5, 8'h33, 4'b0000}) begin
            n_fail++;
            $display("FAIL mulh_then_add: got we=%b addr=%h data=%h flags=%b, want 1/5/33/0000",
                     reg_write_en, reg_write_addr, reg_write_data, flags);
        end
        mf = 4'b0000;
        step();
    endtask

    task automatic test_no_write();
        present(4'hC, 4'd6, 8'h03, 8'h09, 1'b1);
        step();
        present(4'h0, 4'd8, 8'h01, 8'h02, 1'b0);
        n_tests++;
        if ({reg_write_en, flags} !== {1'b0, 4'b0110}) begin
            n_fail++;
            $display("FAIL cmp_nowrite: got we=%b flags=%b, want 0/0110", reg_write_en, flags);
        end
        step();
        present(4'hF, 4'd9, 8'h00, 8'h00, 1'b1);
        n_tests++;
        if ({reg_write_en, flags} !== {1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL add_wb0: got we=%b flags=%b, want 0/0000", reg_write_en, flags);
        end
        step();
        idle();
        n_tests++;
        if ({reg_write_en, flags} !== {1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL nop: got we=%b flags=%b, want 0/0000", reg_write_en, flags);
        end
        mf = 4'b0000;
    endtask

    task automatic test_reset_mid_mul();
        int late;
        late = 0;
        present(4'hD, 4'd9, 8'hAB, 8'hCD, 1'b1);
        step();
        idle();
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready} !== {1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got we=%b addr=%h data=%h flags=%b busy=%b rdy=%b, want 0/0/00/0000/0/1",
                     reg_write_en, reg_write_addr, reg_write_data, flags, busy, in_ready);
        end
        step();
        rst = 1'b0;
        mf = 4'h0;
        for (int k = 0; k < 10; k++) begin
            if (reg_write_en !== 1'b0 || busy !== 1'b0) late++;
            step();
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL rst_abort: got %0d cycles with write/busy after reset, want 0", late);
        end
        present(4'h0, 4'd3, 8'h7F, 8'h01, 1'b1);
        step();
        idle();
        n_tests++;
        if ({reg_write_en, reg_write_addr, reg_write_data, flags} !== {1'b1, 4'd3, 8'h80, 4'b0011}) begin
            n_fail++;
            $display("FAIL add_after_rst: got we=%b addr=%h data=%h flags=%b, want 1/3/80/0011",
                     reg_write_en, reg_write_addr, reg_write_data, flags);
        end
        mf = 4'b0011;
        step();
    endtask

    task automatic test_random();
        logic [3:0]  op, rd;
        logic [7:0]  a, b;
        logic        wb;
        logic [12:0] exp;
        int          stall_bad;
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            wb = 1'($urandom_range(0, 1));
            exp = model_op(op, a, b, wb, mf);
            present(op, rd, a, b, wb);
            step();
            if (op == 4'hD || op == 4'hE) begin
                idle();
                stall_bad = 0;
                for (int k = 0; k < 8; k++) begin
                    if (in_ready !== 1'b0 || reg_write_en !== 1'b0) stall_bad++;
                    step();
                end
                n_tests++;
                if (stall_bad != 0) begin
                    n_fail++;
                    $display("FAIL rand_mul_stall[%0d]: got %0d bad cycles, want 0", n, stall_bad);
                end
            end
            n_tests++;
            if (reg_write_en !== exp[12] || flags !== exp[3:0] ||
                (exp[12] && (reg_write_addr !== rd || reg_write_data !== exp[11:4]))) begin
                n_fail++;
                $display("FAIL rand_op[%0d] op=%h a=%h b=%h wb=%b: got we=%b addr=%h data=%h flags=%b, want we=%b addr=%h data=%h flags=%b",
                         n, op, a, b, wb, reg_write_en, reg_write_addr, reg_write_data, flags,
                         exp[12], rd, exp[11:4], exp[3:0]);
            end
            mf = exp[3:0];
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step();
                n_tests++;
                if (reg_write_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_gap[%0d]: got we=%b, want 0", n, reg_write_en);
                end
            end
        end
        idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_mul_ff();
        test_mul_hold_off();
        test_no_write();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
